dcache_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache. It answers the MEM stage's data-memory requests (address, byte write enables, write data) and returns read data with a one-cycle `dm_ready` pulse. On a miss it refills a 4-word line from a synchronous backing RAM that has one-cycle read latency. It sits between the MEM stage and the data RAM and replaces the direct RAM connection.

---
 rtl/dcache_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the MEM stage and a synchronous data RAM with one-cycle read
// latency. Lines are four words; a load miss refills the whole line.
module dcache_responder #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_REFILL   = 3'd2,
    S_UNCACHED = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  // Replace the enabled byte lanes of old_w with those of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [31:2]       req_addr_q, req_addr_d;
  logic [3:0]        req_wen_q, req_wen_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              dm_ready_q, dm_ready_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        iss_q, iss_d;
  logic [1:0]        rcv_q, rcv_d;
  // rd_iss: mem_addr this cycle is a read; rd_vld: mem_rdata this cycle is valid
  logic              rd_iss_q, rd_iss_d;
  logic              rd_vld_q, rd_vld_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_W-1:0]      tag_s;
  logic [1:0]            off_s;
  logic [1:0]            iss_next_s;
  logic                  uncached_s;
  logic                  store_s;
  logic                  hit_s;
  logic [31:0]           hit_word_s;
  logic                  data_we_s;
  logic [1:0]            data_word_s;
  logic [31:0]           data_wval_s;
  logic                  tag_we_s;
  logic                  unused_addr_s;

  assign unused_addr_s = ^dm_addr[1:0];
  assign idx_s         = req_addr_q[4+INDEX_BITS-1:4];
  assign tag_s         = req_addr_q[31:4+INDEX_BITS];
  assign off_s         = req_addr_q[3:2];
  assign iss_next_s    = iss_q + 2'd1;
  assign uncached_s    = (req_addr_q[31:29] == 3'b101);
  assign store_s       = (req_wen_q != 4'b0000);
  assign hit_word_s    = data_q[idx_s][off_s];
  assign hit_s         = !uncached_s && valid_q[idx_s] && (tag_q[idx_s] == tag_s);

  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, output-register and array-write-enable logic for the controller.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_ready_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = 4'b0000;
    mem_wdata_d = mem_wdata_q;
    iss_d       = iss_q;
    rcv_d       = rcv_q;
    rd_iss_d    = 1'b0;
    rd_vld_d    = rd_iss_q;
    valid_d     = valid_q;
    data_we_s   = 1'b0;
    data_word_s = off_s;
    data_wval_s = 32'h0000_0000;
    tag_we_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dm_req) begin
          req_addr_d  = dm_addr[31:2];
          req_wen_d   = dm_wen;
          req_wdata_d = dm_wdata;
          state_d     = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (store_s) begin
          // Write-through; the line is only touched when it already holds the word.
          mem_addr_d  = {req_addr_q[31:2], 2'b00};
          mem_wen_d   = req_wen_q;
          mem_wdata_d = req_wdata_q;
          if (hit_s) begin
            data_we_s   = 1'b1;
            data_wval_s = merge_bytes(hit_word_s, req_wdata_q, req_wen_q);
          end else begin
            data_we_s = 1'b0;
          end
          dm_ready_d = 1'b1;
          state_d    = S_RESP;
        end else if (hit_s) begin
          dm_rdata_d = hit_word_s;
          dm_ready_d = 1'b1;
          state_d    = S_RESP;
        end else if (uncached_s) begin
          mem_addr_d = {req_addr_q[31:2], 2'b00};
          rd_iss_d   = 1'b1;
          state_d    = S_UNCACHED;
        end else begin
          // Invalidate first so a reset mid-refill never leaves a half-filled valid line.
          valid_d[idx_s] = 1'b0;
          mem_addr_d     = {req_addr_q[31:4], 4'h0};
          rd_iss_d       = 1'b1;
          iss_d          = 2'd0;
          rcv_d          = 2'd0;
          state_d        = S_REFILL;
        end
      end
      S_REFILL: begin
        // Word 0 was issued from LOOKUP; issue words 1..3 on consecutive cycles.
        if (iss_q != 2'd3) begin
          mem_addr_d = {req_addr_q[31:4], iss_next_s, 2'b00};
          iss_d      = iss_next_s;
          rd_iss_d   = 1'b1;
        end else begin
          iss_d = iss_q;
        end
        if (rd_vld_q) begin
          data_we_s   = 1'b1;
          data_word_s = rcv_q;
          data_wval_s = mem_rdata;
          rcv_d       = rcv_q + 2'd1;
          if (rcv_q == off_s) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          if (rcv_q == 2'd3) begin
            valid_d[idx_s] = 1'b1;
            tag_we_s       = 1'b1;
            dm_ready_d     = 1'b1;
            state_d        = S_RESP;
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          state_d = S_REFILL;
        end
      end
      S_UNCACHED: begin
        if (rd_vld_q) begin
          dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_UNCACHED;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state, request latch, outputs and valid bits; reset discards in-flight reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_addr_q  <= 30'd0;
      req_wen_q   <= 4'b0000;
      req_wdata_q <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      dm_ready_q  <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wen_q   <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      iss_q       <= 2'd0;
      rcv_q       <= 2'd0;
      rd_iss_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wdata_q <= req_wdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_ready_q  <= dm_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      iss_q       <= iss_d;
      rcv_q       <= rcv_d;
      rd_iss_q    <= rd_iss_d;
      rd_vld_q    <= rd_vld_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays; contents are qualified by valid_q so they need no reset.
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_q[idx_s][data_word_s] <= data_wval_s;
    end
    if (tag_we_s) begin
      tag_q[idx_s] <= tag_s;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a behavioural backing RAM, a request-level model
// of the cache (tags/valids plus a reference memory image) and one compare
// process that checks every DUT output each cycle.
module tb_dcache_responder;

  logic        clk;
  logic        reset;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dcache_responder #(.INDEX_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Power-on RAM image, indexed by word address bits [11:2].
  function automatic logic [31:0] init_word(input logic [9:0] wi);
    case (wi)
      10'h004: init_word = 32'hCAFE_F00D;
      10'h010: init_word = 32'h1122_3344;
      10'h011: init_word = 32'h5566_7788;
      10'h012: init_word = 32'h99AA_BBCC;
      10'h013: init_word = 32'hDDEE_FF00;
      default: init_word = {6'd0, wi, 6'd0, wi} ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  logic [31:0] ram [1024];
  logic        ram_fill;

  // Backing RAM: byte-enabled writes, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i[9:0]);
      mem_rdata <= 32'h0000_0000;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wen[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  // Request-level model state.
  logic [31:0] mdl_ram [1024];
  bit          mdl_valid [16];
  logic [23:0] mdl_tag [16];

  // Per-cycle expectations, written by the driver and read by the compare process.
  logic        chk_en;
  logic        exp_ready;
  logic [3:0]  exp_wen;
  logic [31:0] exp_maddr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_rdata;
  logic        exp_rdata_en;
  logic        lit_en;
  logic [31:0] lit_val;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Compare DUT outputs against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dm_ready", {31'd0, dm_ready}, {31'd0, exp_ready});
      chk("mem_wen", {28'd0, mem_wen}, {28'd0, exp_wen});
      chk("mem_addr", mem_addr, exp_maddr);
      chk("mem_wdata", mem_wdata, exp_wdata);
      if (exp_rdata_en) chk("dm_rdata", dm_rdata, exp_rdata);
      if (exp_ready && lit_en) chk("dm_rdata_literal", dm_rdata, lit_val);
    end
  end

  task automatic do_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_ready    = 1'b0;
      exp_wen      = 4'b0000;
      exp_rdata_en = 1'b1;
      lit_en       = 1'b0;
    end
  endtask

  // One request; abort_at != 0 asserts reset in that cycle of the access.
  task automatic do_req(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                        input logic use_lit, input logic [31:0] lit, input int abort_at);
    logic [9:0]  wi;
    logic [3:0]  idx;
    logic [23:0] tg;
    logic        unc, hit, store, cmiss, aborted;
    int          lat;
    wi      = a[11:2];
    idx     = a[7:4];
    tg      = a[31:8];
    unc     = (a[31:29] == 3'b101);
    hit     = !unc && mdl_valid[idx] && (mdl_tag[idx] == tg);
    store   = (wen != 4'b0000);
    cmiss   = !store && !hit && !unc;
    lat     = (store || hit) ? 2 : (unc ? 4 : 7);
    aborted = 1'b0;

    @(posedge clk); #1;
    dm_req       = 1'b1;
    dm_addr      = a;
    dm_wen       = wen;
    dm_wdata     = wd;
    exp_ready    = 1'b0;
    exp_wen      = 4'b0000;
    exp_rdata_en = 1'b1;
    lit_en       = use_lit;
    lit_val      = lit;
    if (cmiss) mdl_valid[idx] = 1'b0;

    for (int c = 1; c <= lat; c++) begin
      if (!aborted) begin
        @(posedge clk); #1;
        if (c == abort_at) begin
          reset        = 1'b1;
          dm_req       = 1'b0;
          aborted      = 1'b1;
          exp_ready    = 1'b0;
          exp_wen      = 4'b0000;
          exp_maddr    = 32'h0000_0000;
          exp_wdata    = 32'h0000_0000;
          exp_rdata    = 32'h0000_0000;
          exp_rdata_en = 1'b1;
          lit_en       = 1'b0;
          for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
        end else begin
          if (c == lat) dm_req = 1'b0;
          exp_ready = (c == lat);
          exp_wen   = (store && c == 2) ? wen : 4'b0000;
          if (c == 2 && (store || unc)) exp_maddr = {a[31:2], 2'b00};
          if (c == 2 && store) exp_wdata = wd;
          if (cmiss && c >= 2 && c <= 5) exp_maddr = {a[31:4], 4'h0} + 32'(4 * (c - 2));
          // During a refill the requested word may be captured before dm_ready.
          exp_rdata_en = !(cmiss && c >= 4 && c < lat);
          if (c == lat && !store) exp_rdata = mdl_ram[wi];
        end
      end
    end

    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      if (store) begin
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) mdl_ram[wi][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (cmiss) begin
        mdl_valid[idx] = 1'b1;
        mdl_tag[idx]   = tg;
      end
    end
  endtask

  // Directed stimulus sequence.
  initial begin
    reset        = 1'b0;
    ram_fill     = 1'b1;
    dm_req       = 1'b0;
    dm_addr      = 32'h0000_0000;
    dm_wen       = 4'b0000;
    dm_wdata     = 32'h0000_0000;
    exp_ready    = 1'b0;
    exp_wen      = 4'b0000;
    exp_maddr    = 32'h0000_0000;
    exp_wdata    = 32'h0000_0000;
    exp_rdata    = 32'h0000_0000;
    exp_rdata_en = 1'b1;
    lit_en       = 1'b0;
    lit_val      = 32'h0000_0000;
    for (int i = 0; i < 1024; i++) mdl_ram[i] = init_word(i[9:0]);
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_tag[i]   = 24'd0;
    end
    chk_en = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_fill = 1'b0;
    reset    = 1'b0;

    // Cold miss, then hits on the refilled line (low address bits ignored).
    do_req(32'h0000_0048, 4'b0000, 32'h0, 1'b1, 32'h99AA_BBCC, 0);
    do_req(32'h0000_0040, 4'b0000, 32'h0, 1'b1, 32'h1122_3344, 0);
    do_idle(1);
    do_req(32'h0000_004B, 4'b0000, 32'h0, 1'b1, 32'h99AA_BBCC, 0);
    // Byte store hit, then read-back of the merged word.
    do_req(32'h0000_0040, 4'b0100, 32'h00AB_0000, 1'b0, 32'h0, 0);
    do_req(32'h0000_0040, 4'b0000, 32'h0, 1'b1, 32'h11AB_3344, 0);
    // Conflict eviction and refetch including the write-through byte.
    do_req(32'h0000_0440, 4'b0000, 32'h0, 1'b0, 32'h0, 0);
    do_idle(2);
    do_req(32'h0000_0040, 4'b0000, 32'h0, 1'b1, 32'h11AB_3344, 0);
    do_req(32'h0000_004C, 4'b0000, 32'h0, 1'b1, 32'hDDEE_FF00, 0);
    // Uncached loads never allocate.
    do_req(32'hA000_0010, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 0);
    do_req(32'hA000_0010, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D, 0);
    // Full-word store miss does not allocate.
    do_req(32'h0000_0080, 4'b1111, 32'h1234_5678, 1'b0, 32'h0, 0);
    do_req(32'h0000_0080, 4'b0000, 32'h0, 1'b1, 32'h1234_5678, 0);
    // Uncached partial store.
    do_req(32'hA000_0014, 4'b0011, 32'h0000_BEEF, 1'b0, 32'h0, 0);
    do_req(32'hA000_0014, 4'b0000, 32'h0, 1'b1, 32'hA5A0_BEEF, 0);
    // Store miss on a conflicting line, then miss with merged RAM contents.
    do_req(32'h0000_0444, 4'b1000, 32'h7700_0000, 1'b0, 32'h0, 0);
    do_idle(1);
    do_req(32'h0000_0444, 4'b0000, 32'h0, 1'b1, 32'h77B4_A4B4, 0);
    // Reset in cycle 4 of a refill, then a full refill of the same address.
    do_req(32'h0000_0048, 4'b0000, 32'h0, 1'b0, 32'h0, 4);
    do_req(32'h0000_0048, 4'b0000, 32'h0, 1'b1, 32'h99AA_BBCC, 0);
    do_req(32'h0000_0044, 4'b0000, 32'h0, 1'b1, 32'h5566_7788, 0);
    do_idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
